// File: rtl/nvdla_wr_arb_pkg.sv
// Shared definitions for the NVDLA write-DMA arbiter: packet field offsets,
// packet type encodings and the lock FSM states.
package nvdla_wr_arb_pkg;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 64;
  localparam int SIZE_LSB = 64;
  localparam int SIZE_W   = 13;
  localparam int ACK_BIT  = 77;
  localparam int TYPE_BIT = 129;
  localparam int BEAT_W   = 14;

  localparam logic PKT_CMD = 1'b0;
  localparam logic PKT_DAT = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DAT  = 1'b1
  } arb_state_e;

  // size field holds beats-1; the extra bit keeps 8191+1 from wrapping
  function automatic logic [BEAT_W-1:0] beats_of(input logic [SIZE_W-1:0] size);
    return {1'b0, size} + BEAT_W'(1);
  endfunction

endpackage

// File: rtl/nvdla_wr_arb_ack_fifo.sv
// Flop FIFO holding the client id of every outstanding require_ack command,
// in issue order. Push and pop together are accepted even when full.
module nvdla_wr_arb_ack_fifo #(
  parameter int DEPTH = 8,
  parameter int ID_W  = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [ID_W-1:0] push_id,
  input  logic            pop,
  output logic [ID_W-1:0] head_id,
  output logic            full,
  output logic            empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_q;
  logic [AW:0]     rd_q;
  logic [ID_W-1:0] mem_q [DEPTH];
  logic            push_en_s;
  logic            pop_en_s;

  // Status flags and qualified push/pop; head is read before the write lands
  always_comb begin
    empty     = (wr_q == rd_q);
    full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_en_s  = pop & ~empty;
    push_en_s = push & (~full | pop_en_s);
    head_id   = mem_q[rd_q[AW-1:0]];
  end

  // Pointer and storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en_s) begin
        mem_q[wr_q[AW-1:0]] <= push_id;
        wr_q                <= wr_q + (AW+1)'(1);
      end
      if (pop_en_s) begin
        rd_q <= rd_q + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/nvdla_wr_arb_chk.sv
// Simulation checker for the write arbiter: a data beat may only be presented
// by the client that currently holds the packet lock.
module nvdla_wr_arb_chk #(
  parameter int NUM_CLIENTS = 3,
  parameter int CID_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CLIENTS-1:0] valid_i,
  input  logic [NUM_CLIENTS-1:0] is_dat_i,
  input  logic                   in_dat_i,
  input  logic [CID_W-1:0]       gnt_i
);

  logic [NUM_CLIENTS-1:0] stray_s;

  // Flag any valid data beat from a client that does not own the lock
  always_comb begin
    stray_s = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      stray_s[i] = valid_i[i] & is_dat_i[i] & ~(in_dat_i & (gnt_i == CID_W'(i)));
    end
  end

  a_no_stray_dat: assert property (@(posedge clk) disable iff (rst) stray_s == '0);

endmodule

// File: rtl/nvdla_dmaif_wr_arb.sv
// Round-robin, packet-locked arbiter merging NUM_CLIENTS write-DMA streams onto
// one MCIF write port, with in-order completion routing. Optional stall
// counters are built when NVDLA_WR_ARB_PERF_EN is defined.
module nvdla_dmaif_wr_arb #(
  parameter int NUM_CLIENTS = 3,
  parameter int PD_W        = 130,
  parameter int ACK_DEPTH   = 8,
  parameter int CID_W       = 3
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rst,
  input  logic [NUM_CLIENTS-1:0]      clt_wr_req_valid,
  output logic [NUM_CLIENTS-1:0]      clt_wr_req_ready,
  input  logic [NUM_CLIENTS*PD_W-1:0] clt_wr_req_pd,
  output logic [NUM_CLIENTS-1:0]      clt_wr_rsp_complete,
  output logic                        arb2mcif_wr_req_valid,
  input  logic                        arb2mcif_wr_req_ready,
  output logic [PD_W-1:0]             arb2mcif_wr_req_pd,
  input  logic                        mcif2arb_wr_rsp_complete,
`ifdef NVDLA_WR_ARB_PERF_EN
  input  logic                        reg2arb_perf_en,
  output logic [NUM_CLIENTS*32-1:0]   arb2reg_stall_cnt,
`endif
  output logic                        arb_ack_err
);

  import nvdla_wr_arb_pkg::*;

  arb_state_e             state_q;
  logic [CID_W-1:0]       gnt_q;
  logic [CID_W-1:0]       last_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [NUM_CLIENTS-1:0] cpl_q;
  logic [NUM_CLIENTS-1:0] cpl_d;
  logic                   err_q;
  logic                   err_d;

  logic [NUM_CLIENTS-1:0] is_dat_s;
  logic [NUM_CLIENTS-1:0] elig_s;
  logic [NUM_CLIENTS-1:0] rdy_s;
  logic [CID_W-1:0]       win_s;
  logic                   win_vld_s;
  logic [CID_W-1:0]       sel_s;
  logic [PD_W-1:0]        sel_pd_s;
  logic                   out_vld_s;
  logic                   accept_s;
  logic                   push_s;
  logic                   pop_s;
  logic [CID_W-1:0]       head_s;
  logic                   full_s;
  logic                   empty_s;
  int                     idx_s;

  // Per-client decode: a cmd needing an ack slot is held back while the FIFO is full
  always_comb begin
    is_dat_s = '0;
    elig_s   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      is_dat_s[i] = (clt_wr_req_pd[i*PD_W + TYPE_BIT] == PKT_DAT);
      elig_s[i]   = clt_wr_req_valid[i] & ~is_dat_s[i]
                    & ~(clt_wr_req_pd[i*PD_W + ACK_BIT] & full_s);
    end
  end

  // Round-robin search starting just after the last granted client
  always_comb begin
    win_s     = '0;
    win_vld_s = 1'b0;
    idx_s     = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      idx_s = int'(last_q) + 32'sd1 + k;
      if (idx_s >= NUM_CLIENTS) begin
        idx_s = idx_s - NUM_CLIENTS;
      end else begin
        idx_s = idx_s;
      end
      if (!win_vld_s && elig_s[idx_s]) begin
        win_vld_s = 1'b1;
        win_s     = CID_W'(idx_s);
      end else begin
        win_vld_s = win_vld_s;
      end
    end
  end

  // Source select: the locked client in DAT, the RR winner in IDLE
  always_comb begin
    sel_s     = win_s;
    out_vld_s = 1'b0;
    if (nvdla_core_rst) begin
      out_vld_s = 1'b0;
    end else if (state_q == ST_DAT) begin
      sel_s     = gnt_q;
      out_vld_s = clt_wr_req_valid[gnt_q] & is_dat_s[gnt_q];
    end else begin
      out_vld_s = win_vld_s;
    end
  end

  assign sel_pd_s = clt_wr_req_pd[int'(sel_s)*PD_W +: PD_W];

  // Backpressure goes only to the selected client
  always_comb begin
    rdy_s = '0;
    if (out_vld_s) begin
      rdy_s[sel_s] = arb2mcif_wr_req_ready;
    end else begin
      rdy_s = '0;
    end
  end

  assign accept_s              = out_vld_s & arb2mcif_wr_req_ready;
  assign push_s                = accept_s & (state_q == ST_IDLE) & sel_pd_s[ACK_BIT];
  assign pop_s                 = mcif2arb_wr_rsp_complete & ~empty_s;
  assign clt_wr_req_ready      = rdy_s;
  assign arb2mcif_wr_req_valid = out_vld_s;
  assign arb2mcif_wr_req_pd    = out_vld_s ? sel_pd_s : '0;
  assign clt_wr_rsp_complete   = cpl_q;
  assign arb_ack_err           = err_q;

  // Packet lock FSM with beat counter and round-robin pointer
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= CID_W'(NUM_CLIENTS - 1);
      beat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            gnt_q   <= win_s;
            beat_q  <= beats_of(sel_pd_s[SIZE_LSB +: SIZE_W]);
            state_q <= ST_DAT;
          end
        end
        ST_DAT: begin
          if (accept_s) begin
            beat_q <= beat_q - BEAT_W'(1);
            if (beat_q == BEAT_W'(1)) begin
              state_q <= ST_IDLE;
              last_q  <= gnt_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  nvdla_wr_arb_ack_fifo #(
    .DEPTH (ACK_DEPTH),
    .ID_W  (CID_W)
  ) u_ack_fifo (
    .clk     (nvdla_core_clk),
    .rst     (nvdla_core_rst),
    .push    (push_s),
    .push_id (win_s),
    .pop     (pop_s),
    .head_id (head_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Completion routing; a completion with nothing outstanding is a sticky error
  always_comb begin
    cpl_d = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cpl_d[i] = pop_s && (head_s == CID_W'(i));
    end
    err_d = err_q | (mcif2arb_wr_rsp_complete & empty_s);
  end

  // Registered completion pulse and error flag
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cpl_q <= '0;
      err_q <= 1'b0;
    end else begin
      cpl_q <= cpl_d;
      err_q <= err_d;
    end
  end

`ifdef NVDLA_WR_ARB_PERF_EN
  logic        perf_en_q;
  logic [31:0] stall_q [NUM_CLIENTS];

  // Saturating per-client stall counters, restarted on each enable rising edge
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      perf_en_q <= 1'b0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        stall_q[i] <= '0;
      end
    end else begin
      perf_en_q <= reg2arb_perf_en;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (reg2arb_perf_en & ~perf_en_q) begin
          stall_q[i] <= '0;
        end else if (reg2arb_perf_en & clt_wr_req_valid[i] & ~rdy_s[i]
                     & (stall_q[i] != 32'hFFFF_FFFF)) begin
          stall_q[i] <= stall_q[i] + 32'd1;
        end
      end
    end
  end

  // Flatten counters onto the register bus
  always_comb begin
    arb2reg_stall_cnt = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      arb2reg_stall_cnt[i*32 +: 32] = stall_q[i];
    end
  end
`endif

  nvdla_wr_arb_chk #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .CID_W       (CID_W)
  ) u_chk (
    .clk      (nvdla_core_clk),
    .rst      (nvdla_core_rst),
    .valid_i  (clt_wr_req_valid),
    .is_dat_i (is_dat_s),
    .in_dat_i (state_q == ST_DAT),
    .gnt_i    (gnt_q)
  );

endmodule

// File: tb/tb_nvdla_dmaif_wr_arb.sv
// Table-driven bench for nvdla_dmaif_wr_arb: per-cycle vectors with hand-computed
// expectations, plus hand-written reset-abort and stall-counter sequences.
module tb_nvdla_dmaif_wr_arb;
  import nvdla_wr_arb_pkg::*;

  localparam int N  = 3;
  localparam int PW = 130;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    clt_valid;
  logic [N-1:0]    clt_ready;
  logic [N*PW-1:0] clt_pd;
  logic [N-1:0]    clt_cpl;
  logic            m_valid;
  logic            m_ready;
  logic [PW-1:0]   m_pd;
  logic            m_cpl;
  logic            ack_err;
`ifdef NVDLA_WR_ARB_PERF_EN
  logic            perf_en;
  logic [N*32-1:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic          rst;
    logic [N-1:0]  vld;
    logic [N*PW-1:0] pd;
    logic          rdy;
    logic          cmpl;
    logic          ev;
    logic [N-1:0]  er;
    logic [PW-1:0] ep;
    logic [N-1:0]  ec;
    logic          ee;
  } vec_t;

  vec_t vq[$];

  nvdla_dmaif_wr_arb #(
    .NUM_CLIENTS (N),
    .PD_W        (PW),
    .ACK_DEPTH   (8),
    .CID_W       (3)
  ) dut (
    .nvdla_core_clk           (clk),
    .nvdla_core_rst           (rst),
    .clt_wr_req_valid         (clt_valid),
    .clt_wr_req_ready         (clt_ready),
    .clt_wr_req_pd            (clt_pd),
    .clt_wr_rsp_complete      (clt_cpl),
    .arb2mcif_wr_req_valid    (m_valid),
    .arb2mcif_wr_req_ready    (m_ready),
    .arb2mcif_wr_req_pd       (m_pd),
    .mcif2arb_wr_rsp_complete (m_cpl),
`ifdef NVDLA_WR_ARB_PERF_EN
    .reg2arb_perf_en          (perf_en),
    .arb2reg_stall_cnt        (stall_cnt),
`endif
    .arb_ack_err              (ack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] CMD(input int c, input int size, input logic ack);
    logic [PW-1:0] p;
    p = '0;
    p[ADDR_LSB +: ADDR_W] = 64'hC0DE_0000 + 64'(c);
    p[SIZE_LSB +: SIZE_W] = SIZE_W'(size);
    p[ACK_BIT]            = ack;
    p[TYPE_BIT]           = 1'b0;
    return p;
  endfunction

  function automatic logic [PW-1:0] DAT(input int c, input int b);
    logic [PW-1:0] p;
    p = '0;
    p[63:0]     = 64'hDA7A_0000 + 64'(c * 16 + b);
    p[TYPE_BIT] = 1'b1;
    return p;
  endfunction

  function automatic vec_t V(input logic r, input logic [N-1:0] vld,
                             input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                             input logic [PW-1:0] p2, input logic rdy, input logic cmpl,
                             input logic ev, input logic [N-1:0] er, input logic [PW-1:0] ep,
                             input logic [N-1:0] ec, input logic ee);
    vec_t v;
    v.rst = r; v.vld = vld; v.pd = {p2, p1, p0}; v.rdy = rdy; v.cmpl = cmpl;
    v.ev = ev; v.er = er; v.ep = ep; v.ec = ec; v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(posedge clk);
    #1;
    rst       = v.rst;
    clt_valid = v.vld;
    clt_pd    = v.pd;
    m_ready   = v.rdy;
    m_cpl     = v.cmpl;
    #3;
    chk($sformatf("v%0d valid", idx), PW'(m_valid), PW'(v.ev));
    chk($sformatf("v%0d ready", idx), PW'(clt_ready), PW'(v.er));
    chk($sformatf("v%0d pd", idx), m_pd, v.ep);
    chk($sformatf("v%0d cpl", idx), PW'(clt_cpl), PW'(v.ec));
    chk($sformatf("v%0d err", idx), PW'(ack_err), PW'(v.ee));
  endtask

  initial begin
    logic [PW-1:0] Z;
    Z = '0;
    rst = 1'b1; clt_valid = '0; clt_pd = '0; m_ready = 1'b0; m_cpl = 1'b0;
`ifdef NVDLA_WR_ARB_PERF_EN
    perf_en = 1'b0;
`endif

    // reset state
    vq.push_back(V(1, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b000, 0));
    vq.push_back(V(1, 3'b111, CMD(0,0,0), CMD(1,0,0), CMD(2,0,0), 1, 0, 0, 3'b000, Z, 3'b000, 0));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b000, 0));
    // 1: three single-beat packets, grant order 0,1,2
    vq.push_back(V(0, 3'b111, CMD(0,0,0), CMD(1,0,0), CMD(2,0,0), 1, 0, 1, 3'b001, CMD(0,0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b111, DAT(0,0), CMD(1,0,0), CMD(2,0,0), 1, 0, 1, 3'b001, DAT(0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b110, Z, CMD(1,0,0), CMD(2,0,0), 1, 0, 1, 3'b010, CMD(1,0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b110, Z, DAT(1,0), CMD(2,0,0), 1, 0, 1, 3'b010, DAT(1,0), 3'b000, 0));
    vq.push_back(V(0, 3'b100, Z, Z, CMD(2,0,0), 1, 0, 1, 3'b100, CMD(2,0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b100, Z, Z, DAT(2,0), 1, 0, 1, 3'b100, DAT(2,0), 3'b000, 0));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b000, 0));
    // 2: client 1 four-beat packet locks out client 0
    vq.push_back(V(0, 3'b001, CMD(0,0,0), Z, Z, 1, 0, 1, 3'b001, CMD(0,0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b001, DAT(0,0), Z, Z, 1, 0, 1, 3'b001, DAT(0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b011, CMD(0,0,0), CMD(1,3,0), Z, 1, 0, 1, 3'b010, CMD(1,3,0), 3'b000, 0));
    vq.push_back(V(0, 3'b011, CMD(0,0,0), DAT(1,0), Z, 1, 0, 1, 3'b010, DAT(1,0), 3'b000, 0));
    vq.push_back(V(0, 3'b011, CMD(0,0,0), DAT(1,1), Z, 0, 0, 1, 3'b000, DAT(1,1), 3'b000, 0));
    vq.push_back(V(0, 3'b011, CMD(0,0,0), DAT(1,1), Z, 1, 0, 1, 3'b010, DAT(1,1), 3'b000, 0));
    vq.push_back(V(0, 3'b011, CMD(0,0,0), DAT(1,2), Z, 1, 0, 1, 3'b010, DAT(1,2), 3'b000, 0));
    vq.push_back(V(0, 3'b011, CMD(0,0,0), DAT(1,3), Z, 1, 0, 1, 3'b010, DAT(1,3), 3'b000, 0));
    vq.push_back(V(0, 3'b001, CMD(0,0,0), Z, Z, 1, 0, 1, 3'b001, CMD(0,0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b101, CMD(0,0,0), Z, CMD(2,0,0), 1, 0, 0, 3'b000, Z, 3'b000, 0));
    vq.push_back(V(0, 3'b001, DAT(0,0), Z, Z, 1, 0, 1, 3'b001, DAT(0,0), 3'b000, 0));
    // 3: eight acked packets fill the FIFO, the ninth waits for a completion
    for (int k = 0; k < 8; k++) begin
      vq.push_back(V(0, 3'b100, Z, Z, CMD(2,0,1), 1, 0, 1, 3'b100, CMD(2,0,1), 3'b000, 0));
      vq.push_back(V(0, 3'b100, Z, Z, DAT(2,0), 1, 0, 1, 3'b100, DAT(2,0), 3'b000, 0));
    end
    vq.push_back(V(0, 3'b100, Z, Z, CMD(2,0,1), 1, 0, 0, 3'b000, Z, 3'b000, 0));
    vq.push_back(V(0, 3'b100, Z, Z, CMD(2,0,1), 1, 1, 0, 3'b000, Z, 3'b000, 0));
    vq.push_back(V(0, 3'b100, Z, Z, CMD(2,0,1), 1, 0, 1, 3'b100, CMD(2,0,1), 3'b100, 0));
    vq.push_back(V(0, 3'b100, Z, Z, DAT(2,0), 1, 0, 1, 3'b100, DAT(2,0), 3'b000, 0));
    for (int k = 0; k < 8; k++) begin
      vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 1, 0, 3'b000, Z, (k == 0) ? 3'b000 : 3'b100, 0));
    end
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b100, 0));
    // 4: acks queued 0,2,1 come back in that order
    vq.push_back(V(0, 3'b001, CMD(0,0,1), Z, Z, 1, 0, 1, 3'b001, CMD(0,0,1), 3'b000, 0));
    vq.push_back(V(0, 3'b001, DAT(0,0), Z, Z, 1, 0, 1, 3'b001, DAT(0,0), 3'b000, 0));
    vq.push_back(V(0, 3'b100, Z, Z, CMD(2,0,1), 1, 0, 1, 3'b100, CMD(2,0,1), 3'b000, 0));
    vq.push_back(V(0, 3'b100, Z, Z, DAT(2,0), 1, 0, 1, 3'b100, DAT(2,0), 3'b000, 0));
    vq.push_back(V(0, 3'b010, Z, CMD(1,0,1), Z, 1, 0, 1, 3'b010, CMD(1,0,1), 3'b000, 0));
    vq.push_back(V(0, 3'b010, Z, DAT(1,0), Z, 1, 0, 1, 3'b010, DAT(1,0), 3'b000, 0));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 1, 0, 3'b000, Z, 3'b000, 0));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 1, 0, 3'b000, Z, 3'b001, 0));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 1, 0, 3'b000, Z, 3'b100, 0));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b010, 0));
    // 5: completion with nothing outstanding
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 1, 0, 3'b000, Z, 3'b000, 0));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b000, 1));
    vq.push_back(V(0, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b000, 1));

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], i);
    end

    // 6: reset two beats into a four-beat packet
    run_vec(V(0, 3'b010, Z, CMD(1,3,0), Z, 1, 0, 1, 3'b010, CMD(1,3,0), 3'b000, 1), 1000);
    run_vec(V(0, 3'b010, Z, DAT(1,0), Z, 1, 0, 1, 3'b010, DAT(1,0), 3'b000, 1), 1001);
    run_vec(V(0, 3'b010, Z, DAT(1,1), Z, 1, 0, 1, 3'b010, DAT(1,1), 3'b000, 1), 1002);
    run_vec(V(1, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b000, 1), 1003);
    run_vec(V(0, 3'b111, CMD(0,0,0), CMD(1,0,0), CMD(2,0,0), 1, 0, 1, 3'b001, CMD(0,0,0), 3'b000, 0), 1004);
    run_vec(V(0, 3'b111, DAT(0,0), CMD(1,0,0), CMD(2,0,0), 1, 0, 1, 3'b001, DAT(0,0), 3'b000, 0), 1005);
    run_vec(V(0, 3'b000, Z, Z, Z, 1, 0, 0, 3'b000, Z, 3'b000, 0), 1006);

`ifdef NVDLA_WR_ARB_PERF_EN
    // stall counter: client 1 held off for five cycles
    @(posedge clk); #1;
    perf_en = 1'b1; clt_valid = '0; m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      clt_valid = 3'b010;
      clt_pd    = {Z, CMD(1,0,0), Z};
    end
    @(posedge clk); #1;
    clt_valid = '0;
    #3;
    chk("stall_cnt1", PW'(stall_cnt[63:32]), PW'(32'd5));
    chk("stall_cnt0", PW'(stall_cnt[31:0]), PW'(32'd0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
